// File: rtl/serial_min2_finder_if.sv
// Handshake bundle for serial_min2_finder: input beat stream, flush and result bank.
interface serial_min2_finder_if #(
   parameter int WIDTH = 7,
   parameter int DEG   = 24
);
   localparam int IDX_W = $clog2(DEG);

   // input beat stream
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_mag;
   logic             in_sign;
   logic             in_flush;

   // result bank
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] min_v;
   logic [WIDTH-1:0] submin_v;
   logic [IDX_W-1:0] min_idx;
   logic             sign_xor;

   // block side
   modport slave (
      input  in_valid, in_mag, in_sign, in_flush, out_ready,
      output in_ready, out_valid, min_v, submin_v, min_idx, sign_xor
   );

   // source/sink side
   modport master (
      output in_valid, in_mag, in_sign, in_flush, out_ready,
      input  in_ready, out_valid, min_v, submin_v, min_idx, sign_xor
   );
endinterface

// File: rtl/serial_min2_finder.sv
// Streaming min/submin finder for a min-sum check node. One sign-magnitude beat
// per cycle; after DEG beats the row's min, submin, min index and sign XOR are
// loaded into a result bank so the next row can accumulate meanwhile.
module serial_min2_finder #(
   parameter int WIDTH = 7,
   parameter int DEG   = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_min2_finder_if.slave  bus
);
   localparam int IDX_W = $clog2(DEG);
   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(DEG - 1);

   // row accumulator; cnt doubles as the EMPTY/ACCUM/LAST state
   logic [IDX_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc_min;
   logic [WIDTH-1:0] r_acc_sub;
   logic [IDX_W-1:0] r_acc_idx;
   logic             r_acc_sgn;

   // result bank
   logic             r_out_valid;
   logic [WIDTH-1:0] r_min_v;
   logic [WIDTH-1:0] r_submin_v;
   logic [IDX_W-1:0] r_min_idx;
   logic             r_sign_xor;

   logic             w_first;
   logic             w_last;
   logic             w_in_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_nxt_min;
   logic [WIDTH-1:0] w_nxt_sub;
   logic [IDX_W-1:0] w_nxt_idx;
   logic             w_nxt_sgn;

   assign w_first    = (r_cnt == '0);
   assign w_last     = (r_cnt == LAST_CNT);
   // only the closing beat of a row needs a free bank
   assign w_in_ready = !(w_last && r_out_valid && !bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready && !bus.in_flush;

   // accumulator update for the beat currently presented (strict less-than keeps earliest index on ties)
   always_comb begin
      w_nxt_min = r_acc_min;
      w_nxt_sub = r_acc_sub;
      w_nxt_idx = r_acc_idx;
      w_nxt_sgn = r_acc_sgn ^ bus.in_sign;
      if (w_first) begin
         w_nxt_min = bus.in_mag;
         w_nxt_sub = '1;
         w_nxt_idx = '0;
         w_nxt_sgn = bus.in_sign;
      end else if (bus.in_mag < r_acc_min) begin
         w_nxt_sub = r_acc_min;
         w_nxt_min = bus.in_mag;
         w_nxt_idx = r_cnt;
      end else if (bus.in_mag < r_acc_sub) begin
         w_nxt_sub = bus.in_mag;
      end
   end

   // beat counter and accumulators; flush discards the partial row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_acc_min <= '0;
         r_acc_sub <= '0;
         r_acc_idx <= '0;
         r_acc_sgn <= 1'b0;
      end else if (bus.in_flush) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt     <= w_last ? '0 : r_cnt + IDX_W'(1);
         r_acc_min <= w_nxt_min;
         r_acc_sub <= w_nxt_sub;
         r_acc_idx <= w_nxt_idx;
         r_acc_sgn <= w_nxt_sgn;
      end
   end

   // result bank: load on the closing beat, clear valid on consumption
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_min_v     <= '0;
         r_submin_v  <= '0;
         r_min_idx   <= '0;
         r_sign_xor  <= 1'b0;
      end else if (w_accept && w_last) begin
         r_out_valid <= 1'b1;
         r_min_v     <= w_nxt_min;
         r_submin_v  <= w_nxt_sub;
         r_min_idx   <= w_nxt_idx;
         r_sign_xor  <= w_nxt_sgn;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.min_v     = r_min_v;
   assign bus.submin_v  = r_submin_v;
   assign bus.min_idx   = r_min_idx;
   assign bus.sign_xor  = r_sign_xor;
endmodule

// File: tb/tb_serial_min2_finder.sv
// Directed bench for serial_min2_finder (WIDTH=7, DEG=24): table of rows with
// hand-computed results, plus sequences for stall, flush and async reset.
module tb_serial_min2_finder;
   localparam int WIDTH = 7;
   localparam int DEG   = 24;
   localparam int NROWS = 8;

   typedef struct packed {
      logic [DEG-1:0][WIDTH-1:0] mag;
      logic [DEG-1:0]            sgn;
      logic [WIDTH-1:0]          e_min;
      logic [WIDTH-1:0]          e_sub;
      logic [4:0]                e_idx;
      logic                      e_sx;
   } vec_t;

   typedef struct packed {
      logic [WIDTH-1:0] mn;
      logic [WIDTH-1:0] sb;
      logic [4:0]       ix;
      logic             sx;
      logic [31:0]      cyc;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_min2_finder_if #(.WIDTH(WIDTH), .DEG(DEG)) bus ();

   serial_min2_finder #(.WIDTH(WIDTH), .DEG(DEG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   vec_t        tab [NROWS];
   res_t        mon_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          stalls  = 0;
   logic [31:0] cyc     = 0;
   bit          mon_en  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en && bus.out_valid && bus.out_ready)
         mon_q.push_back({bus.min_v, bus.submin_v, bus.min_idx, bus.sign_xor, cyc});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_row(input string name, input int r);
      chk({name, ".valid"}, 32'(bus.out_valid), 1);
      chk({name, ".min"},   32'(bus.min_v),     32'(tab[r].e_min));
      chk({name, ".sub"},   32'(bus.submin_v),  32'(tab[r].e_sub));
      chk({name, ".idx"},   32'(bus.min_idx),   32'(tab[r].e_idx));
      chk({name, ".sx"},    32'(bus.sign_xor),  32'(tab[r].e_sx));
   endtask

   task automatic drive_beat(input int r, input int b);
      int guard;
      bus.in_valid = 1'b1;
      bus.in_mag   = tab[r].mag[b];
      bus.in_sign  = tab[r].sgn[b];
      @(negedge clk);
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         stalls++;
         @(negedge clk);
         guard++;
      end
      if (!bus.in_ready) chk("beat_timeout", 32'(bus.in_ready), 1);
      @(posedge clk); #1;
   endtask

   task automatic stream_row(input int r);
      for (int b = 0; b < DEG; b++) drive_beat(r, b);
   endtask

   task automatic fill(input int r, input logic [WIDTH-1:0] base);
      for (int b = 0; b < DEG; b++) begin
         tab[r].mag[b] = base;
         tab[r].sgn[b] = 1'b0;
      end
   endtask

   initial begin
      // row 0: all 20, idx5=3, idx17=7, signs at 2 and 9
      fill(0, 7'd20); tab[0].mag[5] = 7'd3; tab[0].mag[17] = 7'd7;
      tab[0].sgn[2] = 1'b1; tab[0].sgn[9] = 1'b1;
      tab[0].e_min = 7'd3; tab[0].e_sub = 7'd7; tab[0].e_idx = 5'd5; tab[0].e_sx = 1'b0;
      // row 1: all equal 10
      fill(1, 7'd10);
      tab[1].e_min = 7'd10; tab[1].e_sub = 7'd10; tab[1].e_idx = 5'd0; tab[1].e_sx = 1'b0;
      // row 2: all 127, one sign on the first beat
      fill(2, 7'd127); tab[2].sgn[0] = 1'b1;
      tab[2].e_min = 7'd127; tab[2].e_sub = 7'd127; tab[2].e_idx = 5'd0; tab[2].e_sx = 1'b1;
      // row 3: descending 23..0, sign on the last beat
      fill(3, 7'd0);
      for (int b = 0; b < DEG; b++) tab[3].mag[b] = 7'(23 - b);
      tab[3].sgn[23] = 1'b1;
      tab[3].e_min = 7'd0; tab[3].e_sub = 7'd1; tab[3].e_idx = 5'd23; tab[3].e_sx = 1'b1;
      // row 4: ascending 1..24, signs on odd beats (12 ones)
      fill(4, 7'd0);
      for (int b = 0; b < DEG; b++) begin
         tab[4].mag[b] = 7'(b + 1);
         tab[4].sgn[b] = 1'(b % 2);
      end
      tab[4].e_min = 7'd1; tab[4].e_sub = 7'd2; tab[4].e_idx = 5'd0; tab[4].e_sx = 1'b0;
      // row 5: tie at idx10/idx11 -> earliest index, submin equals min
      fill(5, 7'd50); tab[5].mag[10] = 7'd5; tab[5].mag[11] = 7'd5;
      tab[5].sgn[3] = 1'b1; tab[5].sgn[4] = 1'b1; tab[5].sgn[7] = 1'b1;
      tab[5].e_min = 7'd5; tab[5].e_sub = 7'd5; tab[5].e_idx = 5'd10; tab[5].e_sx = 1'b1;
      // row 6: min on the closing beat, submin on the beat before
      fill(6, 7'd100); tab[6].mag[22] = 7'd9; tab[6].mag[23] = 7'd8;
      tab[6].sgn[0] = 1'b1; tab[6].sgn[23] = 1'b1;
      tab[6].e_min = 7'd8; tab[6].e_sub = 7'd9; tab[6].e_idx = 5'd23; tab[6].e_sx = 1'b0;
      // row 7: zero on first beat, all signs set (24 ones)
      fill(7, 7'd127); tab[7].mag[0] = 7'd0;
      for (int b = 0; b < DEG; b++) tab[7].sgn[b] = 1'b1;
      tab[7].e_min = 7'd0; tab[7].e_sub = 7'd127; tab[7].e_idx = 5'd0; tab[7].e_sx = 1'b0;

      bus.in_valid = 1'b0; bus.in_mag = '0; bus.in_sign = 1'b0;
      bus.in_flush = 1'b0; bus.out_ready = 1'b0;

      // reset state
      #3;
      chk("rst.valid", 32'(bus.out_valid), 0);
      chk("rst.min",   32'(bus.min_v), 0);
      chk("rst.ready", 32'(bus.in_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // single row, one-cycle latency after the closing beat
      for (int b = 0; b < DEG - 1; b++) drive_beat(0, b);
      chk("lat.pre_valid", 32'(bus.out_valid), 0);
      drive_beat(0, DEG - 1);
      bus.in_valid = 1'b0;
      chk_row("row0", 0);

      // second row while bank is full: only the closing beat stalls
      stalls = 0;
      for (int b = 0; b < DEG - 1; b++) drive_beat(1, b);
      chk("stall.early", 32'(stalls), 0);
      bus.in_valid = 1'b1; bus.in_mag = tab[1].mag[23]; bus.in_sign = tab[1].sgn[23];
      @(negedge clk);
      chk("stall.ready0", 32'(bus.in_ready), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stall.ready0_hold", 32'(bus.in_ready), 0);
      chk_row("stall.hold", 0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("stall.ready1", 32'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk_row("row1_reload", 1);
      @(posedge clk); #1;
      chk("drain.valid", 32'(bus.out_valid), 0);

      // back-to-back rows, out_ready high throughout
      stalls = 0;
      mon_q.delete();
      mon_en = 1;
      for (int r = 0; r < NROWS; r++) stream_row(r);
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 mon_en = 0;
      chk("stream.stalls", 32'(stalls), 0);
      chk("stream.count", 32'(mon_q.size()), NROWS);
      for (int r = 0; r < NROWS; r++) begin
         if (r < mon_q.size()) begin
            chk($sformatf("stream%0d.min", r), 32'(mon_q[r].mn), 32'(tab[r].e_min));
            chk($sformatf("stream%0d.sub", r), 32'(mon_q[r].sb), 32'(tab[r].e_sub));
            chk($sformatf("stream%0d.idx", r), 32'(mon_q[r].ix), 32'(tab[r].e_idx));
            chk($sformatf("stream%0d.sx",  r), 32'(mon_q[r].sx), 32'(tab[r].e_sx));
            if (r > 0)
               chk($sformatf("stream%0d.gap", r), mon_q[r].cyc - mon_q[r-1].cyc, DEG);
         end
      end

      // flush mid-row while a result is pending
      bus.out_ready = 1'b0;
      stream_row(2);
      bus.in_valid = 1'b0;
      chk_row("flush.pending", 2);
      for (int b = 0; b < 10; b++) drive_beat(3, b);
      bus.in_valid = 1'b1; bus.in_flush = 1'b1; bus.in_mag = 7'd0; bus.in_sign = 1'b1;
      @(posedge clk); #1;
      bus.in_flush = 1'b0; bus.in_valid = 1'b0;
      chk_row("flush.bank", 2);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("flush.consumed", 32'(bus.out_valid), 0);
      stream_row(4);
      bus.in_valid = 1'b0;
      chk_row("flush.newrow", 4);
      @(posedge clk); #1;

      // asynchronous reset between edges, mid-row with a pending result
      bus.out_ready = 1'b0;
      stream_row(5);
      for (int b = 0; b < 5; b++) drive_beat(6, b);
      bus.in_valid = 1'b0;
      chk_row("arst.pre", 5);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst.valid", 32'(bus.out_valid), 0);
      chk("arst.min",   32'(bus.min_v), 0);
      chk("arst.sub",   32'(bus.submin_v), 0);
      chk("arst.idx",   32'(bus.min_idx), 0);
      chk("arst.sx",    32'(bus.sign_xor), 0);
      chk("arst.ready", 32'(bus.in_ready), 1);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      stream_row(6);
      bus.in_valid = 1'b0;
      chk_row("arst.newrow", 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
